// File: rtl/sweep_pkg.sv
// Shared types and helpers for the exhaustive sweep / MISR capture engine.
package sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } sweep_state_t;

  localparam int SETTLE_W = 8;
  localparam int VEC_MAX  = 16;

  // Reflected binary code of an index; callers cast the result to their vector width.
  function automatic logic [VEC_MAX-1:0] gray_of(input logic [VEC_MAX-1:0] i);
    return i ^ (i >> 1);
  endfunction

endpackage

// File: rtl/sweep_capture_misr_if.sv
// Capture record stream from the sweep engine to the logging path.
// Valid/ready: a record transfers on a rising edge where cap_valid and cap_ready are both 1;
// once cap_valid rises, cap_vec and cap_resp hold steady until that transfer.
interface sweep_capture_misr_if #(
  parameter int N_WIDTH   = 5,
  parameter int OUT_WIDTH = 1
);
  logic                 cap_valid;
  logic                 cap_ready;
  logic [N_WIDTH-1:0]   cap_vec;
  logic [OUT_WIDTH-1:0] cap_resp;

  modport master (output cap_valid, output cap_vec, output cap_resp, input cap_ready);
  modport slave  (input cap_valid, input cap_vec, input cap_resp, output cap_ready);
endinterface

// File: rtl/misr_reg.sv
// Galois-style multiple-input signature register with synchronous seed load.
module misr_reg #(
  parameter int                   SIG_WIDTH = 16,
  parameter int                   IN_WIDTH  = 1,
  parameter logic [SIG_WIDTH-1:0] POLY      = 16'hD008
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [SIG_WIDTH-1:0] seed,
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [SIG_WIDTH-1:0] sig
);

  logic [SIG_WIDTH-1:0] din_ext;
  logic [SIG_WIDTH-1:0] feedback;
  logic [SIG_WIDTH-1:0] sig_next;

  always_comb begin
    din_ext                = '0;
    din_ext[IN_WIDTH-1:0]  = din;
    feedback               = sig[SIG_WIDTH-1] ? POLY : '0;
    sig_next               = (sig << 1) ^ feedback ^ din_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/sweep_capture_misr.sv
// Exhaustive input sweep (binary or Gray order) with settle wait, streamed capture records
// and a MISR signature compared against a golden value at the end of the sweep.
module sweep_capture_misr
  import sweep_pkg::*;
#(
  parameter int                   N_WIDTH       = 5,
  parameter int                   OUT_WIDTH     = 1,
  parameter int                   SIG_WIDTH     = 16,
  parameter logic [SIG_WIDTH-1:0] POLY          = 16'hD008,
  parameter logic [SIG_WIDTH-1:0] SEED          = 16'hFFFF,
  parameter int                   SETTLE_CYCLES = 1
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  gray_mode,
  input  logic [SIG_WIDTH-1:0]  golden_sig,
  output logic [N_WIDTH-1:0]    stim,
  input  logic [OUT_WIDTH-1:0]  dut_out,
  sweep_capture_misr_if.master  cap,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [SIG_WIDTH-1:0]  signature,
  output sweep_state_t          dbg_state
);

  localparam int                  NUM_VEC     = 2 ** N_WIDTH;
  localparam logic [N_WIDTH:0]    IDX_LAST    = (N_WIDTH+1)'(NUM_VEC - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  sweep_state_t          state_q, state_d;
  logic [N_WIDTH:0]      idx_q;
  logic [N_WIDTH:0]      idx_nxt;
  logic [SETTLE_W-1:0]   settle_q;
  logic                  gray_q;
  logic [SIG_WIDTH-1:0]  golden_q;
  logic [N_WIDTH-1:0]    stim_q;
  logic [N_WIDTH-1:0]    vec_nxt;
  logic                  cap_valid_q;
  logic [OUT_WIDTH-1:0]  cap_resp_q;
  logic                  pass_q;

  logic start_go;
  logic abort_go;
  logic enter_cap;
  logic hs;
  logic last_vec;

  assign idx_nxt  = idx_q + (N_WIDTH+1)'(1);
  assign vec_nxt  = gray_q ? N_WIDTH'(gray_of(VEC_MAX'(idx_nxt))) : idx_nxt[N_WIDTH-1:0];
  assign last_vec = (idx_q == IDX_LAST);

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_go  = 1'b0;
    abort_go  = 1'b0;
    enter_cap = 1'b0;
    hs        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_APPLY;
          start_go = 1'b1;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_d  = S_IDLE;
          abort_go = 1'b1;
        end else if (SETTLE_CYCLES == 0) begin
          state_d   = S_CAPTURE;
          enter_cap = 1'b1;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d  = S_IDLE;
          abort_go = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          state_d   = S_CAPTURE;
          enter_cap = 1'b1;
        end
      end
      S_CAPTURE: begin
        // abort outranks a transfer offered in the same cycle
        if (abort) begin
          state_d  = S_IDLE;
          abort_go = 1'b1;
        end else if (cap_valid_q && cap.cap_ready) begin
          hs      = 1'b1;
          state_d = last_vec ? S_DONE : S_APPLY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      settle_q    <= '0;
      gray_q      <= 1'b0;
      golden_q    <= '0;
      stim_q      <= '0;
      cap_valid_q <= 1'b0;
      cap_resp_q  <= '0;
      pass_q      <= 1'b0;
    end else begin
      if (state_q == S_APPLY) begin
        settle_q <= '0;
      end else if (state_q == S_SETTLE) begin
        settle_q <= settle_q + SETTLE_W'(1);
      end
      // vector 0 maps to 0 in both orders
      if (start_go) begin
        gray_q   <= gray_mode;
        golden_q <= golden_sig;
        idx_q    <= '0;
        stim_q   <= '0;
        pass_q   <= 1'b0;
      end
      if (enter_cap) begin
        cap_valid_q <= 1'b1;
        cap_resp_q  <= dut_out;
      end
      if (hs) begin
        cap_valid_q <= 1'b0;
        if (!last_vec) begin
          idx_q  <= idx_nxt;
          stim_q <= vec_nxt;
        end
      end
      if (abort_go) begin
        cap_valid_q <= 1'b0;
        pass_q      <= 1'b0;
      end
      if (state_q == S_DONE) begin
        pass_q <= (signature == golden_q);
      end
    end
  end

  misr_reg #(
    .SIG_WIDTH (SIG_WIDTH),
    .IN_WIDTH  (OUT_WIDTH),
    .POLY      (POLY)
  ) u_misr (
    .clk   (CK),
    .rst_n (reset),
    .load  (start_go),
    .seed  (SEED),
    .en    (hs),
    .din   (cap_resp_q),
    .sig   (signature)
  );

  assign stim          = stim_q;
  assign cap.cap_valid = cap_valid_q;
  assign cap.cap_vec   = stim_q;
  assign cap.cap_resp  = cap_resp_q;
  assign busy          = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign done          = (state_q == S_DONE);
  // live compare during the DONE cycle, then held until the next start
  assign pass          = (state_q == S_DONE) ? (signature == golden_q) : pass_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/sweep_capture_misr.md
Name: sweep_capture_misr

Overview:
- Parametrised on-chip stimulus/response engine for trojan-detection characterisation.
- Drives every input vector of an N_WIDTH-bit DUT input space in binary or Gray order, waits a programmable settle time, and samples the DUT output.
- Streams each (vector, response) pair over a valid/ready port for logging, folds the response into a MISR signature, and compares the final signature against a golden value.
- Sits between the DUT wrapper and the capture/log path; replaces open-loop per-benchmark sweeps.

Parameters:
- N_WIDTH, 5, DUT input width; the sweep covers 2**N_WIDTH vectors (1..16).
- OUT_WIDTH, 1, DUT output width; must be <= SIG_WIDTH.
- SIG_WIDTH, 16, MISR width.
- POLY, 16'hD008, Galois feedback taps (bit i set = tap at i).
- SEED, 16'hFFFF, MISR value loaded on start.
- SETTLE_CYCLES, 1, wait cycles between APPLY and CAPTURE (0..255; 0 = none).

Ports:
- CK  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  cancel an active sweep.
- gray_mode  in  1  0 = binary order, 1 = Gray order; latched on start.
- golden_sig  in  SIG_WIDTH  expected final signature; latched on start.
- stim  out  N_WIDTH  registered vector driven to the DUT.
- dut_out  in  OUT_WIDTH  DUT response.
- cap_valid  out  1  capture record valid.
- cap_ready  in  1  consumer accepts the record.
- cap_vec  out  N_WIDTH  vector of the record (equals stim).
- cap_resp  out  OUT_WIDTH  sampled response, registered.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  final signature == golden_sig; valid from done until the next start.
- signature  out  SIG_WIDTH  current MISR value.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; stim=0, cap_valid=0, cap_resp=0, busy=0, done=0, pass=0, signature=0, counters=0.
- States: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE: on start=1, latch gray_mode and golden_sig, load signature=SEED, index=0, stim=f(0), then go to APPLY.
- APPLY (1 cycle): go to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
- SETTLE: hold for exactly SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE, entry cycle: register cap_resp=dut_out and assert cap_valid. cap_resp and stim are held stable until the handshake.
- CAPTURE handshake (cap_valid & cap_ready):
  - Update the MISR: signature = (signature<<1) ^ (signature[MSB] ? POLY : 0) ^ zero-extended cap_resp.
  - cap_valid drops on the next cycle.
  - If index == 2**N_WIDTH-1, go to DONE.
  - Otherwise index++, stim=f(index), go to APPLY.
- Cycles per vector with cap_ready held high = SETTLE_CYCLES + 2.
- cap_ready low: stall indefinitely; signature, stim and index do not change.
- Vector mapping f(i): binary gives i; Gray gives i ^ (i>>1). Index wrap never occurs; the index counter is N_WIDTH+1 bits wide.
- DONE (1 cycle):
  - done=1 and pass=(signature==latched golden_sig).
  - Return to IDLE next cycle.
  - pass, signature and stim hold until the next start.
- abort in any busy state: next cycle go to IDLE, cap_valid=0. done is not pulsed, pass=0, signature holds its partial value. abort has priority over the handshake in the same cycle.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Reset mid-sweep: immediate return to reset values; no done pulse.

Decomposition:
- Package sweep_pkg: state enum sweep_state_t; localparams NUM_VEC=2**N_WIDTH and SETTLE_W=8; function gray_of(i).
- Sub-module misr_reg: parameters SIG_WIDTH, IN_WIDTH, POLY; ports load, seed, en, din, sig.
- The FSM, counters and handshake stay in the top module.

Test Plan:
- Zero response, binary order: N_WIDTH=2, OUT_WIDTH=1, SIG_WIDTH=4, POLY=4'h3, SEED=0, dut_out=0, golden=0, cap_ready=1. Expect stim sequence 0,1,2,3; done after 4*(1+2)=12 cycles; pass=1, signature=0.
- Constant-one response: same configuration with dut_out=1 and golden=4'hF. Expect signature steps 1,3,7,F; pass=1. Rerun with golden=4'hE: expect pass=0.
- Gray order: N_WIDTH=3, gray_mode=1. cap_vec sequence must be 0,1,3,2,6,7,5,4, with exactly 8 handshakes before done.
- Backpressure: hold cap_ready=0 for 5 cycles in CAPTURE of vector 2. cap_valid stays 1; stim, cap_vec and signature are unchanged during the stall. The sweep then completes with the same signature as the no-stall run.
- Abort: assert abort during SETTLE of vector 1. Next cycle is IDLE: busy=0, cap_valid=0, no done pulse, pass=0. A new start reloads SEED and begins at vector 0.
- Asynchronous reset mid-sweep: drop reset between clock edges while in CAPTURE. All outputs go to 0 immediately, without waiting for CK. After reset release, start runs a full sweep correctly.
